// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding LD/ST data-memory controller with fixed access latency over an internal RAM.
// Define DMEM_BOUNDS_CHECK_EN to trap out-of-range addresses (sticky error_o) instead of aliasing them.
module dmem_ctrl #(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        wen_i,
  input  logic        byte_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        yumi_o,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  input  logic        yumi_i,
  output logic        error_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e state, next_state;
  logic [3:0] count;

  logic        req_wen, req_byte;
  logic [31:0] req_addr, req_wdata;

  logic                    acc_wen, acc_byte;
  logic [31:0]             acc_addr, acc_wdata;
  logic [addr_width_p-1:0] acc_idx;
  logic [1:0]              acc_lane;
  logic                    enter_resp;
  logic                    out_of_range;

  logic [31:0] mem [0:(1<<addr_width_p)-1];

  assign yumi_o  = (state == IDLE) & valid_i;
  assign valid_o = (state == RESP);

  // With latency 1 the RAM access shares its edge with the accept, so it must see the live request.
  assign acc_wen    = (state == IDLE) ? wen_i   : req_wen;
  assign acc_byte   = (state == IDLE) ? byte_i  : req_byte;
  assign acc_addr   = (state == IDLE) ? addr_i  : req_addr;
  assign acc_wdata  = (state == IDLE) ? wdata_i : req_wdata;
  assign acc_idx    = acc_addr[addr_width_p+1:2];
  assign acc_lane   = acc_addr[1:0];
  assign enter_resp = (next_state == RESP) && (state != RESP);

`ifdef DMEM_BOUNDS_CHECK_EN
  assign out_of_range = |acc_addr[31:addr_width_p+2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      error_o <= 1'b0;
    end else if (enter_resp && out_of_range) begin
      error_o <= 1'b1;
    end
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[31:addr_width_p+2];
  assign out_of_range   = 1'b0;
  assign error_o        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid_i) next_state = (latency_p == 1) ? RESP : BUSY;
      BUSY:    if (count == 4'd1) next_state = RESP;
      RESP:    if (yumi_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (yumi_o) begin
      count <= 4'(latency_p - 1);
    end else if (state == BUSY) begin
      count <= count - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (yumi_o) begin
      req_wen   <= wen_i;
      req_byte  <= byte_i;
      req_addr  <= addr_i;
      req_wdata <= wdata_i;
    end
  end

  // Reset gates the write so a request dropped by reset never lands in the RAM.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_wen && !out_of_range) begin
      if (acc_byte) begin
        mem[acc_idx][{acc_lane, 3'b000} +: 8] <= acc_wdata[7:0];
      end else begin
        mem[acc_idx] <= acc_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_o <= '0;
    end else if (enter_resp) begin
      if (acc_wen) begin
        rdata_o <= '0;
      end else if (out_of_range) begin
        rdata_o <= 32'hDEADBEEF;
      end else if (acc_byte) begin
        rdata_o <= {24'b0, mem[acc_idx][{acc_lane, 3'b000} +: 8]};
      end else begin
        rdata_o <= mem[acc_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vector table, handshake corner sequences and random traffic checked against a reference memory.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, wen_i, byte_i, yumi_i;
  logic [31:0] addr_i, wdata_i;
  logic        yumi_o, valid_o, error_o;
  logic [31:0] rdata_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [0:DEPTH-1];
  bit          ref_err = 1'b0;

  typedef struct {
    logic        wen;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  dmem_ctrl #(.addr_width_p(ADDR_W), .latency_p(LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .wen_i   (wen_i),
    .byte_i  (byte_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .yumi_o  (yumi_o),
    .valid_o (valid_o),
    .rdata_o (rdata_o),
    .yumi_i  (yumi_i),
    .error_o (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference memory: word index wraps modulo the depth, lanes are little-endian bytes.
  function automatic logic [31:0] modelAccess(input logic w, input logic b,
                                              input logic [31:0] a, input logic [31:0] d);
    int idx;
    int sh;
    idx = int'((a >> 2) % DEPTH);
    sh  = 8 * int'(a % 4);
    if (BOUNDS && ((a >> (ADDR_W + 2)) != 0)) begin
      ref_err = 1'b1;
      return w ? 32'h0 : 32'hDEADBEEF;
    end
    if (w) begin
      if (b) ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      else   ref_mem[idx] = d;
      return 32'h0;
    end
    if (b) return (ref_mem[idx] >> sh) & 32'hFF;
    return ref_mem[idx];
  endfunction

  task automatic applyStimulus(input string name, input logic w, input logic b,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    int n;
    int lat;
    @(negedge clk);
    valid_i = 1'b1; wen_i = w; byte_i = b; addr_i = a; wdata_i = d;
    #1;
    n = 0;
    while (!yumi_o && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({name, "_accept"}, 32'(yumi_o), 32'd1);
    if (!yumi_o) begin
      valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, "_lat"}, 32'(lat), 32'(LAT));
    checkOutput({name, "_rdata"}, rdata_o, exp);
    checkOutput({name, "_err"}, 32'(error_o), 32'(ref_err));
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    checkOutput({name, "_vdrop"}, 32'(valid_o), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ref_err = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d, e;
    logic        w, b;
    int          n;

    reset = 1'b0; valid_i = 1'b0; wen_i = 1'b0; byte_i = 1'b0;
    addr_i = '0; wdata_i = '0; yumi_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_rdata", rdata_o, 32'd0);
    checkOutput("reset_err", 32'(error_o), 32'd0);
    checkOutput("reset_yumi", 32'(yumi_o), 32'd0);
    reset = 1'b1;

    vecs.push_back('{1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h10, 32'h0,        32'hCAFEF00D});
    vecs.push_back('{1'b1, 1'b0, 32'h20, 32'h11223344, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 32'h22, 32'h000000AA, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h20, 32'h0,        32'h11AA3344});
    vecs.push_back('{1'b0, 1'b1, 32'h23, 32'h0,        32'h00000011});
    vecs.push_back('{1'b0, 1'b1, 32'h22, 32'h0,        32'h000000AA});
    vecs.push_back('{1'b0, 1'b1, 32'h20, 32'h0,        32'h00000044});
    vecs.push_back('{1'b1, 1'b0, 32'h3C, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 32'h3F, 32'h12345600, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h3C, 32'h0,        32'h00FFFFFF});
    vecs.push_back('{1'b0, 1'b0, 32'h13, 32'h0,        32'hCAFEF00D});
    vecs.push_back('{1'b1, 1'b0, 32'h30, 32'h0,        32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      void'(modelAccess(vecs[i].wen, vecs[i].byt, vecs[i].addr, vecs[i].wdata));
      applyStimulus($sformatf("vec%0d", i), vecs[i].wen, vecs[i].byt, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    end

    // Backpressure: response held while a new request waits at the input.
    @(negedge clk);
    valid_i = 1'b1; wen_i = 1'b0; byte_i = 1'b0; addr_i = 32'h10; #1;
    checkOutput("bp_accept", 32'(yumi_o), 32'd1);
    @(posedge clk); #1;
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 32'(valid_o), 32'd1);
      checkOutput("bp_rdata", rdata_o, 32'hCAFEF00D);
      checkOutput("bp_yumi", 32'(yumi_o), 32'd0);
      @(posedge clk); #1;
    end
    yumi_i = 1'b1; #1;
    checkOutput("bp_yumi_same_cycle", 32'(yumi_o), 32'd0);
    @(posedge clk); #1;
    yumi_i = 1'b0;
    checkOutput("bp_valid_drop", 32'(valid_o), 32'd0);
    checkOutput("bp_next_accept", 32'(yumi_o), 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_second_rdata", rdata_o, 32'hCAFEF00D);
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;

    // Reset while a store is in BUSY drops the store.
    @(negedge clk);
    valid_i = 1'b1; wen_i = 1'b1; byte_i = 1'b0; addr_i = 32'h30; wdata_i = 32'h55; #1;
    checkOutput("rst_accept", 32'(yumi_o), 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ref_err = 1'b0;
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_valid_later", 32'(valid_o), 32'd0);
    applyStimulus("rst_load", 1'b0, 1'b0, 32'h30, 32'h0, modelAccess(1'b0, 1'b0, 32'h30, 32'h0));

    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      e = modelAccess(1'b1, 1'b0, 32'(i * 4), d);
      applyStimulus("preload", 1'b1, 1'b0, 32'(i * 4), d, e);
    end
    for (int i = 0; i < 100; i++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 7)) << 12);
      d = $urandom;
      e = modelAccess(w, b, a, d);
      applyStimulus($sformatf("rnd%0d", i), w, b, a, d, e);
    end

    pulseReset();
    checkOutput("rst2_err", 32'(error_o), 32'd0);
    void'(modelAccess(1'b1, 1'b0, 32'h0, 32'h0BADF00D));
    applyStimulus("w0_store", 1'b1, 1'b0, 32'h0, 32'h0BADF00D, 32'h0);
`ifdef DMEM_BOUNDS_CHECK_EN
    void'(modelAccess(1'b0, 1'b0, 32'h1000, 32'h0));
    applyStimulus("oob_load", 1'b0, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF);
    checkOutput("oob_err_set", 32'(error_o), 32'd1);
    void'(modelAccess(1'b1, 1'b0, 32'h1000, 32'h12345678));
    applyStimulus("oob_store", 1'b1, 1'b0, 32'h1000, 32'h12345678, 32'h0);
    void'(modelAccess(1'b0, 1'b0, 32'h0, 32'h0));
    applyStimulus("w0_unchanged", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BADF00D);
    checkOutput("oob_err_sticky", 32'(error_o), 32'd1);
    pulseReset();
    checkOutput("oob_err_cleared", 32'(error_o), 32'd0);
`else
    void'(modelAccess(1'b1, 1'b0, 32'h1000, 32'h12345678));
    applyStimulus("alias_store", 1'b1, 1'b0, 32'h1000, 32'h12345678, 32'h0);
    void'(modelAccess(1'b0, 1'b0, 32'h0, 32'h0));
    applyStimulus("alias_load", 1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678);
    checkOutput("alias_err", 32'(error_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
